// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode stage: opcodes, ALU selects and the
// control word handed to the single-cycle datapath.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'h8;

    localparam logic [1:0] FS_PASS = 2'b00;
    localparam logic [1:0] FS_ADD  = 2'b01;
    localparam logic [1:0] FS_MUL  = 2'b10;

    typedef struct packed {
        logic [3:0] aa;
        logic [3:0] ba;
        logic [3:0] da;
        logic [3:0] addr;
        logic [3:0] imm;
        logic [1:0] fs;
        logic       mb;
        logic       md;
        logic       rw;
        logic       mw;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } state_t;

    function automatic logic [15:0] zext4(logic [3:0] v);
        return {12'b0, v};
    endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Bundle between the fetch/decode stage and its environment: run control,
// instruction memory port and the datapath control word.
interface fetch_decode_if #(
    parameter int unsigned PC_W = 8
);

    logic            start;
    logic            stall;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic [15:0]     AA;
    logic [15:0]     BA;
    logic [15:0]     DA;
    logic [15:0]     ADD;
    logic [15:0]     const_in;
    logic [1:0]      FS;
    logic            MB;
    logic            MD;
    logic            RW;
    logic            MW;
    logic            halted;
    logic            illegal;
    logic [15:0]     retired;

    modport master (
        input  start, stall, imem_rdata,
        output imem_addr, AA, BA, DA, ADD, const_in, FS, MB, MD, RW, MW,
               halted, illegal, retired
    );

    modport slave (
        output start, stall, imem_rdata,
        input  imem_addr, AA, BA, DA, ADD, const_in, FS, MB, MD, RW, MW,
               halted, illegal, retired
    );

endinterface

// File: rtl/instr_decoder.sv
// Combinational decode of one 16-bit instruction into a datapath control word
// plus flow-control flags.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0]       instr,
    output logic [CTRL_W-1:0] ctrl,
    output logic              is_jmp,
    output logic              is_halt,
    output logic              is_illegal
);

    logic [3:0] op;
    logic [3:0] f_da;
    logic [3:0] f_aa;
    logic [3:0] f_lo;
    ctrl_t      c;

    assign op   = instr[15:12];
    assign f_da = instr[11:8];
    assign f_aa = instr[7:4];
    assign f_lo = instr[3:0];
    assign ctrl = c;

    always_comb begin
        c          = '0;
        is_jmp     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_NOP: begin
            end
            OP_ADD: begin
                c.fs = FS_ADD;
                c.rw = 1'b1;
                c.da = f_da;
                c.aa = f_aa;
                c.ba = f_lo;
            end
            OP_MUL: begin
                c.fs = FS_MUL;
                c.rw = 1'b1;
                c.da = f_da;
                c.aa = f_aa;
                c.ba = f_lo;
            end
            OP_MOV: begin
                c.fs = FS_PASS;
                c.rw = 1'b1;
                c.da = f_da;
                c.aa = f_aa;
            end
            OP_ADDI: begin
                c.fs  = FS_ADD;
                c.mb  = 1'b1;
                c.imm = f_lo;
                c.rw  = 1'b1;
                c.da  = f_da;
                c.aa  = f_aa;
            end
            OP_LD: begin
                c.md   = 1'b1;
                c.addr = f_lo;
                c.rw   = 1'b1;
                c.da   = f_da;
            end
            OP_ST: begin
                c.mw   = 1'b1;
                c.addr = f_lo;
                c.ba   = f_lo;
            end
            OP_JMP:  is_jmp  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: PC, run/halt FSM, in-flight fetch tracking, registered
// control word and retired-instruction counter.
module fetch_decode
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_decode_if.master bus
);

    localparam logic [PC_W-1:0] RstPc = PC_W'(RESET_PC);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] f_pc_q, f_pc_d;
    logic            f_valid_q, f_valid_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            illegal_q, illegal_d;
    logic [15:0]     retired_q, retired_d;

    ctrl_t           dec_ctrl;
    logic            dec_jmp;
    logic            dec_halt;
    logic            dec_illegal;
    logic [PC_W-1:0] jmp_target;

    instr_decoder u_decoder (
        .instr      (bus.imem_rdata),
        .ctrl       (dec_ctrl),
        .is_jmp     (dec_jmp),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

    assign jmp_target = PC_W'(bus.imem_rdata[7:0]);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        f_pc_d    = f_pc_q;
        f_valid_d = 1'b0;
        ctrl_d    = '0;
        illegal_d = illegal_q;
        retired_d = retired_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.stall) begin
                    // Drop the in-flight fetch and rewind so it is fetched again.
                    if (f_valid_q) begin
                        pc_d = f_pc_q;
                    end
                end else begin
                    pc_d      = pc_q + PC_W'(1);
                    f_pc_d    = pc_q;
                    f_valid_d = 1'b1;
                    if (f_valid_q) begin
                        if (dec_jmp) begin
                            pc_d      = jmp_target;
                            f_valid_d = 1'b0;
                        end else if (dec_halt) begin
                            pc_d      = pc_q;
                            f_valid_d = 1'b0;
                            state_d   = StHalt;
                        end else if (dec_illegal) begin
                            illegal_d = 1'b1;
                        end else if (dec_ctrl.rw || dec_ctrl.mw) begin
                            ctrl_d    = dec_ctrl;
                            retired_d = retired_q + 16'd1;
                        end
                    end
                end
            end
            StHalt: begin
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= RstPc;
            f_pc_q    <= RstPc;
            f_valid_q <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            f_pc_q    <= f_pc_d;
            f_valid_q <= f_valid_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.AA        = zext4(ctrl_q.aa);
    assign bus.BA        = zext4(ctrl_q.ba);
    assign bus.DA        = zext4(ctrl_q.da);
    assign bus.ADD       = zext4(ctrl_q.addr);
    assign bus.const_in  = zext4(ctrl_q.imm);
    assign bus.FS        = ctrl_q.fs;
    assign bus.MB        = ctrl_q.mb;
    assign bus.MD        = ctrl_q.md;
    assign bus.RW        = ctrl_q.rw;
    assign bus.MW        = ctrl_q.mw;
    assign bus.halted    = (state_q == StHalt);
    assign bus.illegal   = illegal_q;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed plus randomized program runs; issued words are compared against an
// instruction-level execution of each program.
module tb_fetch_decode;

    localparam int unsigned PC_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_decode_if #(.PC_W(PC_W)) bus ();

    fetch_decode #(
        .PC_W     (PC_W),
        .RESET_PC (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [256];
    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    int vectors = 0;
    int miscompares = 0;

    logic        capture = 1'b0;
    logic [85:0] got_q [$];
    logic [85:0] exp_q [$];

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [85:0] cur_word();
        return {bus.AA, bus.BA, bus.DA, bus.ADD, bus.const_in,
                bus.FS, bus.MB, bus.MD, bus.RW, bus.MW};
    endfunction

    // Expected control word straight from the instruction-set description.
    function automatic logic [85:0] ref_word(input logic [15:0] i);
        logic [15:0] da, aa, lo;
        da = {12'b0, i[11:8]};
        aa = {12'b0, i[7:4]};
        lo = {12'b0, i[3:0]};
        case (i[15:12])
            4'h1: return {aa, lo, da, 16'h0, 16'h0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
            4'h2: return {aa, lo, da, 16'h0, 16'h0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
            4'h3: return {aa, 16'h0, da, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
            4'h4: return {aa, 16'h0, da, 16'h0, lo, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
            4'h5: return {16'h0, 16'h0, da, lo, 16'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
            4'h6: return {16'h0, lo, 16'h0, lo, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
            default: return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (capture && cur_word() != '0) got_q.push_back(cur_word());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        tick();
        reset = 1'b0;
        check({tag, "_word"}, 96'(cur_word()), 96'(0));
        check({tag, "_pc"}, 96'(bus.imem_addr), 96'(0));
        check({tag, "_flags"}, 96'({bus.halted, bus.illegal}), 96'(0));
        check({tag, "_retired"}, 96'(bus.retired), 96'(0));
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [15:0] instr;
        int unsigned pc, steps, tgt, r, stall_pct, halt_pc;
        logic exp_illegal;
        logic [3:0] op;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        clear_mem();

        // ADD then MUL, first word two cycles after start.
        mem[0] = 16'h1312;
        mem[1] = 16'h2645;
        do_reset("rst0");
        tick();
        check("idle_pc", 96'(bus.imem_addr), 96'(0));
        pulse_start();
        tick();
        check("lat_bubble", 96'(cur_word()), 96'(0));
        tick();
        check("add_word", 96'(cur_word()), 96'(ref_word(16'h1312)));
        check("add_fields", 96'({bus.DA, bus.AA, bus.BA, bus.FS, bus.RW}),
              96'({16'd3, 16'd1, 16'd2, 2'b01, 1'b1}));
        tick();
        check("mul_word", 96'(cur_word()), 96'(ref_word(16'h2645)));
        check("retired_2", 96'(bus.retired), 96'(2));

        // Reset while a register write is on the outputs.
        check("rw_before_rst", 96'(bus.RW), 96'(1));
        do_reset("rst_mid");
        tick();
        tick();
        check("rst_idle_pc", 96'(bus.imem_addr), 96'(0));
        check("rst_idle_word", 96'(cur_word()), 96'(0));

        // JMP squashes the following fetch.
        clear_mem();
        mem[0] = 16'h7010;
        mem[1] = 16'h1111;
        mem[16] = 16'h3700;
        do_reset("rst_jmp");
        pulse_start();
        tick();
        tick();
        check("jmp_bubble0", 96'(cur_word()), 96'(0));
        tick();
        check("jmp_bubble1", 96'(cur_word()), 96'(0));
        tick();
        check("jmp_mov", 96'(cur_word()), 96'(ref_word(16'h3700)));
        check("jmp_retired", 96'(bus.retired), 96'(1));

        // ST then LD.
        clear_mem();
        mem[0] = 16'h6025;
        mem[1] = 16'h5304;
        do_reset("rst_mem");
        pulse_start();
        tick();
        tick();
        check("st_fields", 96'({bus.MW, bus.RW, bus.ADD, bus.BA, bus.AA}),
              96'({1'b1, 1'b0, 16'd5, 16'd5, 16'd0}));
        tick();
        check("ld_fields", 96'({bus.MD, bus.RW, bus.DA, bus.ADD}),
              96'({1'b1, 1'b1, 16'd3, 16'd4}));

        // HALT at address 2.
        clear_mem();
        mem[0] = 16'h1312;
        mem[1] = 16'h2645;
        mem[2] = 16'h8000;
        do_reset("rst_halt");
        pulse_start();
        tick();
        tick();
        tick();
        check("pre_halt", 96'(bus.halted), 96'(0));
        tick();
        check("halted", 96'(bus.halted), 96'(1));
        check("halt_word", 96'(cur_word()), 96'(0));
        check("halt_pc", 96'(bus.imem_addr), 96'(3));
        pulse_start();
        tick();
        tick();
        check("halt_hold", 96'({bus.halted, bus.imem_addr}), 96'({1'b1, 8'd3}));
        check("halt_word2", 96'(cur_word()), 96'(0));
        check("halt_retired", 96'(bus.retired), 96'(2));

        // Undefined opcode: sticky flag, bubble, execution continues.
        clear_mem();
        mem[0] = 16'hF123;
        mem[1] = 16'h1312;
        do_reset("rst_ill");
        pulse_start();
        tick();
        tick();
        check("ill_flag", 96'({bus.illegal, cur_word()}), 96'({1'b1, 86'(0)}));
        tick();
        check("ill_next", 96'(cur_word()), 96'(ref_word(16'h1312)));
        tick();
        tick();
        check("ill_sticky", 96'({bus.illegal, bus.retired}), 96'({1'b1, 16'd1}));

        // Random forward-branching programs ending in HALT, random stalls.
        for (int run = 0; run < 24; run++) begin
            clear_mem();
            for (int unsigned a = 0; a < 31; a++) begin
                r = $urandom_range(0, 99);
                if (r < 60) begin
                    op = 4'($urandom_range(0, 6));
                    mem[a] = {op, 12'($urandom)};
                end else if (r < 78) begin
                    tgt = $urandom_range(a + 1, 31);
                    mem[a] = {4'h7, 4'($urandom), 8'(tgt)};
                end else if (r < 84) begin
                    op = 4'($urandom_range(9, 15));
                    mem[a] = {op, 12'($urandom)};
                end else if (r < 86) begin
                    mem[a] = {4'h8, 12'($urandom)};
                end else begin
                    op = 4'($urandom_range(1, 6));
                    mem[a] = {op, 12'($urandom)};
                end
            end
            mem[31] = 16'h8000;

            exp_q.delete();
            exp_illegal = 1'b0;
            pc = 0;
            halt_pc = 0;
            steps = 0;
            while (steps < 64) begin
                instr = mem[pc];
                steps++;
                if (instr[15:12] == 4'h8) begin
                    halt_pc = (pc + 1) % 256;
                    break;
                end else if (instr[15:12] == 4'h7) begin
                    pc = instr[7:0];
                end else begin
                    if (instr[15:12] >= 4'h9) exp_illegal = 1'b1;
                    else if (instr[15:12] != 4'h0) exp_q.push_back(ref_word(instr));
                    pc = (pc + 1) % 256;
                end
            end

            do_reset("rst_rand");
            got_q.delete();
            capture = 1'b1;
            stall_pct = $urandom_range(0, 50);
            pulse_start();
            for (int cyc = 0; cyc < 500 && !bus.halted; cyc++) begin
                bus.stall = ($urandom_range(0, 99) < stall_pct);
                tick();
            end
            bus.stall = 1'b0;
            tick();
            capture = 1'b0;

            check("rand_halted", 96'(bus.halted), 96'(1));
            check("rand_count", 96'(got_q.size()), 96'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                check("rand_word", 96'(got_q[k]), 96'(exp_q[k]));
            end
            check("rand_retired", 96'(bus.retired), 96'(exp_q.size()));
            check("rand_illegal", 96'(bus.illegal), 96'(exp_illegal));
            check("rand_halt_pc", 96'(bus.imem_addr), 96'(halt_pc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
